genius_round_controller: RTL
============================

// Module: genius_round_controller
// PURPOSE
//  Round sequencer for the Genius memory game. Reads the stored colour sequence from the sequence
//  memory, plays the first N colours on led_seq, then collects and checks N player inputs.
//  Round N grows from 1 up to SEQ_LEN, ending in win or defeat. Sits between the sequence memory
//  (sync-read RAM/ROM) and the board LEDs/buttons inside top_genius_game.
// PARAMETERS
//  SEQ_LEN        8   rounds to win; also memory depth used (>=1)
//  ADDR_W         3   memory address width; 2**ADDR_W >= SEQ_LEN
//  SHOW_CYCLES    4   cycles each colour is lit during playback (>=1)
//  GAP_CYCLES     2   dark cycles after each lit colour (>=1)
//  TIMEOUT_CYCLES 64  max WAIT_IN dwell per input (only with GENIUS_TIMEOUT_EN)
// PORTS
//  clk           in   1             system clock, all logic on rising edge
//  rst_n         in   1             synchronous reset, active-low
//  start         in   1             1-cycle pulse: begin new game (ignored while busy)
//  in_valid      in   1             1-cycle strobe: player_input is a press
//  player_input  in   2             pressed colour 0..3
//  mem_rd_en     out  1             sequence memory read enable
//  mem_addr      out  ADDR_W        sequence memory read address
//  mem_data      in   2             read data, valid exactly 1 cycle after mem_rd_en
//  led_seq       out  4             one-hot lit colour (bit k = colour k), 0 = dark
//  round         out  ADDR_W+1      current round length (1..SEQ_LEN), 0 when idle
//  busy          out  1             1 in any state other than IDLE/WIN/LOSE
//  win           out  1             sticky: game won
//  defeat        out  1             sticky: game lost
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): state=IDLE. led_seq=0, round=0, idx=0, mem_rd_en=0,
//    mem_addr=0, busy=0, win=0, defeat=0. Overrides everything, including mid-game.
//  - All outputs are registered.
//  - States: IDLE, FETCH, SHOW, GAP, PREP, WAIT_IN, WIN, LOSE.
//  - IDLE/WIN/LOSE + start=1: next cycle FETCH, round=1, idx=0, win=0, defeat=0.
//  - start in any busy state: ignored.
//  - FETCH (1 cyc): mem_rd_en=1, mem_addr=idx -> SHOW.
//  - SHOW: on the first cycle, latch exp=mem_data and set led_seq=1<<mem_data.
//    Hold for SHOW_CYCLES cycles -> GAP.
//  - GAP: led_seq=0 for GAP_CYCLES cycles.
//    - If idx+1<round: idx++ -> FETCH.
//    - Else: idx=0 -> PREP.
//  - PREP (1 cyc): mem_rd_en=1, mem_addr=idx -> WAIT_IN. The first WAIT_IN cycle latches exp=mem_data.
//  - WAIT_IN: in_valid is sampled from the cycle after entry. led_seq=0.
//    - match, idx+1<round: idx++ -> PREP.
//    - match, idx+1==round, round<SEQ_LEN: round++, idx=0 -> FETCH.
//    - match, idx+1==round, round==SEQ_LEN: -> WIN, win=1.
//    - mismatch: -> LOSE, defeat=1.
//  - in_valid outside WAIT_IN (incl. its latch cycle): ignored, no state change.
//  - WIN/LOSE: hold. win/defeat stay high until the next accepted start or reset.
//  - Never both win=1 and defeat=1.
//  - Counters: idx is ADDR_W bits and never exceeds SEQ_LEN-1; round never exceeds SEQ_LEN, no wrap.
//    Dwell counters reload on every state entry.
//  - Latency: start to first lit LED = 3 cycles (FETCH, SHOW latch edge).
// CONFIGURATION
//  - GENIUS_TIMEOUT_EN defined:
//    - Each WAIT_IN entry reloads a timer with TIMEOUT_CYCLES.
//    - Expiry with no in_valid -> LOSE, defeat=1.
//    - in_valid in the expiry cycle takes priority over timeout.
//  - GENIUS_TIMEOUT_EN undefined: no timer logic; WAIT_IN waits indefinitely.
// TESTING
//  1. SEQ_LEN=3, memory {2,0,3}, correct presses each round.
//     -> LED playback 2 | 2,0 | 2,0,3, round 1->2->3, win=1, busy=0, defeat=0.
//  2. Memory {1,3,...}, round 2 presses 1 then 2.
//     -> LOSE on the second press, defeat=1, win=0, led_seq=0.
//  3. start pulsed during SHOW of round 2 -> ignored, round stays 2. start after WIN -> round=1, win=0.
//  4. rst_n=0 for 1 cycle mid-SHOW -> next cycle IDLE, led_seq=0, round=0, all flags 0.
//  5. in_valid with a wrong colour during SHOW/GAP -> ignored, playback continues, no defeat.
//  6. GENIUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, no press -> defeat=1 exactly 8 cycles after the WAIT_IN latch.
//     Without the macro -> still WAIT_IN after 1000 cycles.

Source files
------------

// File: rtl/genius_round_controller.sv
// genius_round_controller: Genius memory-game round sequencer (playback, input check, win/lose).
// Define GENIUS_TIMEOUT_EN to make each player input time out after TIMEOUT_CYCLES.
module genius_round_controller #(
    parameter int SEQ_LEN        = 8,
    parameter int ADDR_W         = 3,
    parameter int SHOW_CYCLES    = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [1:0]        player_input,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_data,
    output logic [3:0]        led_seq,
    output logic [ADDR_W:0]   round,
    output logic              busy,
    output logic              win,
    output logic              defeat
);
    localparam int M1    = SHOW_CYCLES > GAP_CYCLES ? SHOW_CYCLES : GAP_CYCLES;
    localparam int M2    = M1 > TIMEOUT_CYCLES ? M1 : TIMEOUT_CYCLES;
    localparam int CNT_W = $clog2(M2 + 2);
    typedef enum logic [2:0] {IDLE, FETCH, SHOW, GAP, PREP, WAIT_IN, WIN, LOSE} state_t;
    state_t            state, state_n;
    logic [ADDR_W-1:0] idx, idx_n;
    logic [ADDR_W:0]   round_n, idx_inc;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [1:0]        exp_c, exp_n;
    logic [3:0]        led_n;
    logic              win_n, defeat_n, more;
    assign idx_inc = {1'b0, idx} + (ADDR_W+1)'(1);
    assign more    = idx_inc < round;
    always_comb begin
        state_n  = state;
        idx_n    = idx;
        round_n  = round;
        exp_n    = exp_c;
        led_n    = led_seq;
        win_n    = win;
        defeat_n = defeat;
        case (state)
            IDLE, WIN, LOSE:
                if (start) begin
                    state_n  = FETCH;
                    round_n  = (ADDR_W+1)'(1);
                    idx_n    = '0;
                    win_n    = 1'b0;
                    defeat_n = 1'b0;
                end
            FETCH: state_n = SHOW;
            SHOW: begin
                if (cnt == '0) begin
                    exp_n = mem_data;
                    led_n = 4'b0001 << mem_data;
                end
                if (cnt == CNT_W'(SHOW_CYCLES)) begin
                    state_n = GAP;
                    led_n   = '0;
                end
            end
            GAP:
                if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    state_n = more ? FETCH : PREP;
                    idx_n   = more ? idx_inc[ADDR_W-1:0] : '0;
                end
            PREP: state_n = WAIT_IN;
            WAIT_IN:
                // The entry cycle only captures the expected colour; presses count afterwards.
                if (cnt == '0) exp_n = mem_data;
                else if (in_valid) begin
                    if (player_input != exp_c) begin
                        state_n  = LOSE;
                        defeat_n = 1'b1;
                    end else if (more) begin
                        state_n = PREP;
                        idx_n   = idx_inc[ADDR_W-1:0];
                    end else if (round < (ADDR_W+1)'(SEQ_LEN)) begin
                        state_n = FETCH;
                        round_n = round + (ADDR_W+1)'(1);
                        idx_n   = '0;
                    end else begin
                        state_n = WIN;
                        win_n   = 1'b1;
                    end
                end
`ifdef GENIUS_TIMEOUT_EN
                else if (cnt == CNT_W'(TIMEOUT_CYCLES)) begin
                    state_n  = LOSE;
                    defeat_n = 1'b1;
                end
`else
`endif
        endcase
        // Dwell counter restarts on every state change and saturates while parked.
        cnt_n = (state_n != state) ? '0 : (&cnt ? cnt : cnt + CNT_W'(1));
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            round     <= '0;
            cnt       <= '0;
            exp_c     <= '0;
            led_seq   <= '0;
            win       <= 1'b0;
            defeat    <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            round     <= round_n;
            cnt       <= cnt_n;
            exp_c     <= exp_n;
            led_seq   <= led_n;
            win       <= win_n;
            defeat    <= defeat_n;
            mem_rd_en <= state_n == FETCH || state_n == PREP;
            mem_addr  <= idx_n;
            busy      <= !(state_n inside {IDLE, WIN, LOSE});
        end
    end
endmodule
